// File: rtl/reg_write_arbiter.sv
// Two-source writeback arbiter for the register file write port.
// Each source has a one-entry slot; grants go oldest-first and pending flags track buffered/in-flight writes.
module reg_write_arbiter #(
  parameter int REGISTER_INDEX_SIZE = 5,
  parameter int DATA_SIZE           = 32,
  parameter int TOTAL_REGISTER_NUM  = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           a_valid,
  output logic                           a_ready,
  input  logic [REGISTER_INDEX_SIZE-1:0] a_reg,
  input  logic [DATA_SIZE-1:0]           a_data,
  input  logic                           b_valid,
  output logic                           b_ready,
  input  logic [REGISTER_INDEX_SIZE-1:0] b_reg,
  input  logic [DATA_SIZE-1:0]           b_data,
  output logic [REGISTER_INDEX_SIZE-1:0] w_reg,
  output logic [DATA_SIZE-1:0]           w_data,
  output logic                           w_enable,
  output logic [TOTAL_REGISTER_NUM-1:0]  pending
);

  logic                           full_a;
  logic                           full_b;
  logic                           a_older;
  logic [REGISTER_INDEX_SIZE-1:0] slot_a_reg;
  logic [REGISTER_INDEX_SIZE-1:0] slot_b_reg;
  logic [DATA_SIZE-1:0]           slot_a_data;
  logic [DATA_SIZE-1:0]           slot_b_data;

  logic grant_a;
  logic grant_b;
  logic load_a;
  logic load_b;

  // Grant and ready are derived from registered state only, never from valid.
  assign grant_a = full_a & (~full_b | a_older);
  assign grant_b = full_b & (~full_a | ~a_older);

  assign a_ready = rst_n & (~full_a | grant_a);
  assign b_ready = rst_n & (~full_b | grant_b);

  // Writes to $zero complete the handshake but never occupy a slot.
  assign load_a = a_valid & a_ready & (a_reg != '0);
  assign load_b = b_valid & b_ready & (b_reg != '0);

  // Control and issue stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_a   <= 1'b0;
      full_b   <= 1'b0;
      a_older  <= 1'b0;
      w_enable <= 1'b0;
      w_reg    <= '0;
      w_data   <= '0;
    end else begin
      if (load_a)       full_a <= 1'b1;
      else if (grant_a) full_a <= 1'b0;

      if (load_b)       full_b <= 1'b1;
      else if (grant_b) full_b <= 1'b0;

      // Age is judged against what remains in the other slot after this edge's grant.
      if (load_a && load_b)
        a_older <= 1'b1;
      else if (load_a && full_b && !grant_b)
        a_older <= 1'b0;
      else if (load_b && full_a && !grant_a)
        a_older <= 1'b1;

      if (grant_a) begin
        w_reg    <= slot_a_reg;
        w_data   <= slot_a_data;
        w_enable <= 1'b1;
      end else if (grant_b) begin
        w_reg    <= slot_b_reg;
        w_data   <= slot_b_data;
        w_enable <= 1'b1;
      end else begin
        w_enable <= 1'b0;
      end
    end
  end

  // Slot payload stage
  always_ff @(posedge clk) begin
    if (load_a) begin
      slot_a_reg  <= a_reg;
      slot_a_data <= a_data;
    end
    if (load_b) begin
      slot_b_reg  <= b_reg;
      slot_b_data <= b_data;
    end
  end

  always_comb begin
    pending = '0;
    for (int r = 1; r < TOTAL_REGISTER_NUM; r++) begin
      pending[r] = (full_a   && (slot_a_reg == REGISTER_INDEX_SIZE'(r))) ||
                   (full_b   && (slot_b_reg == REGISTER_INDEX_SIZE'(r))) ||
                   (w_enable && (w_reg      == REGISTER_INDEX_SIZE'(r)));
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a falling-edge register file model.
module tb_reg_write_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic [4:0]  a_reg = '0, b_reg = '0, w_reg;
  logic [31:0] a_data = '0, b_data = '0, w_data;
  logic        w_enable;
  logic [31:0] pending;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rf [32];

  reg_write_arbiter #(.REGISTER_INDEX_SIZE(5), .DATA_SIZE(32), .TOTAL_REGISTER_NUM(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_ready(a_ready), .a_reg(a_reg), .a_data(a_data),
    .b_valid(b_valid), .b_ready(b_ready), .b_reg(b_reg), .b_data(b_data),
    .w_reg(w_reg), .w_data(w_data), .w_enable(w_enable), .pending(pending)
  );

  always #5 clk = ~clk;

  initial for (int i = 0; i < 32; i++) rf[i] = 32'h0;
  always @(negedge clk) if (w_enable) rf[w_reg] <= w_data;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_valid = 1'b0;
    b_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({a_ready, b_ready, w_enable} !== 3'b000) begin
      miscompares++;
      $display("FAIL reset_ctrl: got %b expected 000", {a_ready, b_ready, w_enable});
    end
    vectors++;
    if (pending !== 32'h0 || w_reg !== 5'd0 || w_data !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_out: pending=%h w_reg=%0d w_data=%h expected all 0", pending, w_reg, w_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single;
    a_valid = 1'b1; a_reg = 5'd3; a_data = 32'h0000_00AA;
    tick;
    idle;
    vectors++;
    if (pending[3] !== 1'b1 || w_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL single_accept: pending[3]=%b w_enable=%b expected 1 0", pending[3], w_enable);
    end
    tick;
    vectors++;
    if (w_enable !== 1'b1 || w_reg !== 5'd3 || w_data !== 32'hAA || pending[3] !== 1'b1) begin
      miscompares++;
      $display("FAIL single_issue: en=%b reg=%0d data=%h pend=%b expected 1 3 aa 1",
               w_enable, w_reg, w_data, pending[3]);
    end
    @(negedge clk); #1;
    vectors++;
    if (rf[3] !== 32'hAA) begin
      miscompares++;
      $display("FAIL single_rf: r3=%h expected 000000aa", rf[3]);
    end
    tick;
    vectors++;
    if (w_enable !== 1'b0 || pending !== 32'h0) begin
      miscompares++;
      $display("FAIL single_clear: en=%b pending=%h expected 0 0", w_enable, pending);
    end
  endtask

  task automatic test_same_edge;
    logic [31:0] exp_p;
    exp_p = 32'h0; exp_p[5] = 1'b1; exp_p[6] = 1'b1;
    a_valid = 1'b1; a_reg = 5'd5; a_data = 32'h11;
    b_valid = 1'b1; b_reg = 5'd6; b_data = 32'h22;
    tick;
    idle;
    vectors++;
    if (a_ready !== 1'b1 || b_ready !== 1'b0 || pending !== exp_p) begin
      miscompares++;
      $display("FAIL same_edge_ready: a_ready=%b b_ready=%b pending=%h expected 1 0 %h",
               a_ready, b_ready, pending, exp_p);
    end
    tick;
    vectors++;
    if (w_enable !== 1'b1 || w_reg !== 5'd5 || w_data !== 32'h11 || b_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL same_edge_first: en=%b reg=%0d data=%h b_ready=%b expected 1 5 11 1",
               w_enable, w_reg, w_data, b_ready);
    end
    tick;
    vectors++;
    if (w_enable !== 1'b1 || w_reg !== 5'd6 || w_data !== 32'h22) begin
      miscompares++;
      $display("FAIL same_edge_second: en=%b reg=%0d data=%h expected 1 6 22", w_enable, w_reg, w_data);
    end
    tick;
    vectors++;
    if (w_enable !== 1'b0 || rf[5] !== 32'h11 || rf[6] !== 32'h22) begin
      miscompares++;
      $display("FAIL same_edge_rf: en=%b r5=%h r6=%h expected 0 11 22", w_enable, rf[5], rf[6]);
    end
  endtask

  task automatic test_same_index;
    a_valid = 1'b1; a_reg = 5'd7; a_data = 32'h1;
    tick;
    a_valid = 1'b0;
    b_valid = 1'b1; b_reg = 5'd7; b_data = 32'h2;
    tick;
    b_valid = 1'b0;
    vectors++;
    if (w_enable !== 1'b1 || w_reg !== 5'd7 || w_data !== 32'h1 || pending[7] !== 1'b1) begin
      miscompares++;
      $display("FAIL same_index_first: en=%b reg=%0d data=%h pend=%b expected 1 7 1 1",
               w_enable, w_reg, w_data, pending[7]);
    end
    tick;
    vectors++;
    if (w_enable !== 1'b1 || w_reg !== 5'd7 || w_data !== 32'h2) begin
      miscompares++;
      $display("FAIL same_index_second: en=%b reg=%0d data=%h expected 1 7 2", w_enable, w_reg, w_data);
    end
    @(negedge clk); #1;
    vectors++;
    if (rf[7] !== 32'h2) begin
      miscompares++;
      $display("FAIL same_index_rf: r7=%h expected 2", rf[7]);
    end
    tick;
  endtask

  task automatic test_alternate;
    logic [4:0] exp_seq [8];
    logic [4:0] got_seq [8];
    int ai, bi, n;
    logic acc_a, acc_b;
    exp_seq = '{5'd10, 5'd20, 5'd11, 5'd21, 5'd12, 5'd22, 5'd13, 5'd23};
    for (int i = 0; i < 8; i++) got_seq[i] = 5'd0;
    ai = 0; bi = 0; n = 0;
    for (int c = 0; c < 11; c++) begin
      a_valid = (ai < 4); a_reg = 5'(10 + ai); a_data = 32'(32'h100 + ai);
      b_valid = (bi < 4); b_reg = 5'(20 + bi); b_data = 32'(32'h200 + bi);
      acc_a = a_valid && a_ready;
      acc_b = b_valid && b_ready;
      tick;
      if (acc_a) ai++;
      if (acc_b) bi++;
      if (w_enable) begin
        if (n < 8) got_seq[n] = w_reg;
        n++;
      end
    end
    idle;
    vectors++;
    if (n != 8) begin
      miscompares++;
      $display("FAIL alternate_count: issued %0d expected 8", n);
    end
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (got_seq[i] !== exp_seq[i]) begin
        miscompares++;
        $display("FAIL alternate_order[%0d]: reg=%0d expected %0d", i, got_seq[i], exp_seq[i]);
      end
    end
  endtask

  task automatic test_stream_a;
    for (int k = 1; k <= 8; k++) begin
      a_valid = 1'b1; a_reg = 5'(k); a_data = 32'(32'h1000 + k);
      vectors++;
      if (a_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL stream_ready[%0d]: a_ready=%b expected 1", k, a_ready);
      end
      tick;
      if (k >= 2) begin
        vectors++;
        if (w_enable !== 1'b1 || w_reg !== 5'(k - 1)) begin
          miscompares++;
          $display("FAIL stream_issue[%0d]: en=%b reg=%0d expected 1 %0d", k, w_enable, w_reg, k - 1);
        end
      end
    end
    idle;
    tick;
    vectors++;
    if (w_enable !== 1'b1 || w_reg !== 5'd8 || w_data !== 32'h1008) begin
      miscompares++;
      $display("FAIL stream_last: en=%b reg=%0d data=%h expected 1 8 1008", w_enable, w_reg, w_data);
    end
    tick;
  endtask

  task automatic test_zero;
    b_valid = 1'b1; b_reg = 5'd0; b_data = 32'hFFFF_FFFF;
    vectors++;
    if (b_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_ready: b_ready=%b expected 1", b_ready);
    end
    tick;
    idle;
    vectors++;
    if (pending !== 32'h0 || w_enable !== 1'b0 || b_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_accept: pending=%h en=%b b_ready=%b expected 0 0 1", pending, w_enable, b_ready);
    end
    tick;
    @(negedge clk); #1;
    vectors++;
    if (w_enable !== 1'b0 || rf[0] !== 32'h0) begin
      miscompares++;
      $display("FAIL zero_rf: en=%b r0=%h expected 0 0", w_enable, rf[0]);
    end
  endtask

  task automatic write_a(input logic [4:0] r, input logic [31:0] d);
    a_valid = 1'b1; a_reg = r; a_data = d;
    tick;
    a_valid = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset_mid;
    logic [31:0] exp_p;
    write_a(5'd12, 32'h55);
    write_a(5'd13, 32'h66);
    write_a(5'd14, 32'h77);
    a_valid = 1'b1; a_reg = 5'd12; a_data = 32'hA1;
    b_valid = 1'b1; b_reg = 5'd13; b_data = 32'hB1;
    tick;
    b_valid = 1'b0;
    a_reg = 5'd14; a_data = 32'hA2;
    tick;
    a_valid = 1'b0;
    exp_p = 32'h0; exp_p[12] = 1'b1; exp_p[13] = 1'b1; exp_p[14] = 1'b1;
    vectors++;
    if (w_enable !== 1'b1 || w_reg !== 5'd12 || pending !== exp_p) begin
      miscompares++;
      $display("FAIL mid_setup: en=%b reg=%0d pending=%h expected 1 12 %h", w_enable, w_reg, pending, exp_p);
    end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if ({w_enable, a_ready, b_ready} !== 3'b000 || pending !== 32'h0) begin
      miscompares++;
      $display("FAIL mid_reset: en/ar/br=%b pending=%h expected 000 0", {w_enable, a_ready, b_ready}, pending);
    end
    @(negedge clk); #1;
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick;
      vectors++;
      if (w_enable !== 1'b0 || pending !== 32'h0) begin
        miscompares++;
        $display("FAIL mid_after[%0d]: en=%b pending=%h expected 0 0", c, w_enable, pending);
      end
    end
    vectors++;
    if (rf[12] !== 32'h55 || rf[13] !== 32'h66 || rf[14] !== 32'h77) begin
      miscompares++;
      $display("FAIL mid_rf: r12=%h r13=%h r14=%h expected 55 66 77", rf[12], rf[13], rf[14]);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_same_edge;
    test_same_index;
    test_alternate;
    test_stream_a;
    test_zero;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
